// File: rtl/cluster_narrow_id_remap_pkg.sv
// rtl/cluster_narrow_id_remap_pkg.sv - default widths and AXI channel structs for the narrow ID remapper
package cluster_narrow_id_remap_pkg;

    localparam int unsigned NarrowIdWidthOut = 6;
    localparam int unsigned AXI_IW           = 4;
    localparam int unsigned AddrWidth        = 32;
    localparam int unsigned DataWidth        = 64;
    localparam int unsigned UserWidth        = 1;

    typedef logic [NarrowIdWidthOut-1:0] slv_id_t;
    typedef logic [AXI_IW-1:0]           mst_id_t;
    typedef logic [AddrWidth-1:0]        addr_t;
    typedef logic [DataWidth-1:0]        data_t;
    typedef logic [DataWidth/8-1:0]      strb_t;
    typedef logic [UserWidth-1:0]        user_t;

    // Index width of a table with n slots; a single-slot table still needs one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        slv_id_t     id;
        addr_t       addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        user_t       user;
    } narrow_out_aw_chan_t;

    typedef struct packed {
        mst_id_t     id;
        addr_t       addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        logic [5:0]  atop;
        user_t       user;
    } narrow_in_aw_chan_t;

    typedef struct packed {
        data_t data;
        strb_t strb;
        logic  last;
        user_t user;
    } narrow_w_chan_t;

    typedef struct packed {
        slv_id_t    id;
        logic [1:0] resp;
        user_t      user;
    } narrow_out_b_chan_t;

    typedef struct packed {
        mst_id_t    id;
        logic [1:0] resp;
        user_t      user;
    } narrow_in_b_chan_t;

    typedef struct packed {
        slv_id_t     id;
        addr_t       addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        user_t       user;
    } narrow_out_ar_chan_t;

    typedef struct packed {
        mst_id_t     id;
        addr_t       addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
        logic [3:0]  region;
        user_t       user;
    } narrow_in_ar_chan_t;

    typedef struct packed {
        slv_id_t    id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } narrow_out_r_chan_t;

    typedef struct packed {
        mst_id_t    id;
        data_t      data;
        logic [1:0] resp;
        logic       last;
        user_t      user;
    } narrow_in_r_chan_t;

    typedef struct packed {
        narrow_out_aw_chan_t aw;
        logic                aw_valid;
        narrow_w_chan_t      w;
        logic                w_valid;
        logic                b_ready;
        narrow_out_ar_chan_t ar;
        logic                ar_valid;
        logic                r_ready;
    } narrow_out_req_t;

    typedef struct packed {
        logic               aw_ready;
        logic               ar_ready;
        logic               w_ready;
        logic               b_valid;
        narrow_out_b_chan_t b;
        logic               r_valid;
        narrow_out_r_chan_t r;
    } narrow_out_resp_t;

    typedef struct packed {
        narrow_in_aw_chan_t aw;
        logic               aw_valid;
        narrow_w_chan_t     w;
        logic               w_valid;
        logic               b_ready;
        narrow_in_ar_chan_t ar;
        logic               ar_valid;
        logic               r_ready;
    } narrow_in_req_t;

    typedef struct packed {
        logic              aw_ready;
        logic              ar_ready;
        logic              w_ready;
        logic              b_valid;
        narrow_in_b_chan_t b;
        logic              r_valid;
        narrow_in_r_chan_t r;
    } narrow_in_resp_t;

endpackage

// File: rtl/cluster_id_remap_table.sv
// rtl/cluster_id_remap_table.sv - per-direction ID slot table: lookup, allocation, counting, readout
module cluster_id_remap_table
    import cluster_narrow_id_remap_pkg::*;
#(
    parameter int unsigned IdWidth      = 6,
    parameter int unsigned MaxUniqIds   = 4,
    parameter int unsigned MaxTxnsPerId = 4,
    parameter int unsigned IdxWidth     = idx_width(MaxUniqIds)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [IdWidth-1:0]  req_id,
    input  logic                push,
    output logic                stall,
    output logic [IdxWidth-1:0] slot,
    input  logic                pop,
    input  logic [IdxWidth-1:0] pop_idx,
    output logic [IdWidth-1:0]  pop_orig_id,
    output logic                busy
);

    localparam int unsigned CntWidth = $clog2(MaxTxnsPerId + 1);

    typedef struct packed {
        logic                valid;
        logic [IdWidth-1:0]  orig_id;
        logic [CntWidth-1:0] cnt;
    } id_table_entry_t;

    id_table_entry_t [MaxUniqIds-1:0] tbl;

    logic                  hit;
    logic [IdxWidth-1:0]   hit_idx;
    logic                  free_found;
    logic [IdxWidth-1:0]   free_idx;
    logic                  saturated;
    logic [MaxUniqIds-1:0] inc_vec;
    logic [MaxUniqIds-1:0] dec_vec;

    // Match lookup and lowest-free priority encoder over the registered table only.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        busy       = 1'b0;
        for (int i = 0; i < MaxUniqIds; i++) begin
            if (tbl[i].valid && tbl[i].orig_id == req_id) begin
                hit     = 1'b1;
                hit_idx = IdxWidth'(i);
            end
            busy = busy | tbl[i].valid;
        end
        for (int i = MaxUniqIds - 1; i >= 0; i--) begin
            if (!tbl[i].valid) begin
                free_found = 1'b1;
                free_idx   = IdxWidth'(i);
            end
        end
        saturated   = hit && (tbl[hit_idx].cnt == CntWidth'(MaxTxnsPerId));
        stall       = hit ? saturated : !free_found;
        slot        = hit ? hit_idx : free_idx;
        pop_orig_id = tbl[pop_idx].orig_id;
    end

    // Per-slot increment/decrement strobes for this cycle's handshakes.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < MaxUniqIds; i++) begin
            inc_vec[i] = push && (slot == IdxWidth'(i));
            dec_vec[i] = pop && (pop_idx == IdxWidth'(i));
        end
    end

    // Counter update; a slot pushed and popped in the same cycle keeps its state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tbl <= '0;
        end else begin
            for (int i = 0; i < MaxUniqIds; i++) begin
                if (inc_vec[i] && !dec_vec[i]) begin
                    if (tbl[i].valid) begin
                        tbl[i].cnt <= tbl[i].cnt + CntWidth'(1);
                    end else begin
                        tbl[i].valid   <= 1'b1;
                        tbl[i].orig_id <= req_id;
                        tbl[i].cnt     <= CntWidth'(1);
                    end
                end else if (dec_vec[i] && !inc_vec[i]) begin
                    tbl[i].cnt <= tbl[i].cnt - CntWidth'(1);
                    if (tbl[i].cnt == CntWidth'(1)) begin
                        tbl[i].valid <= 1'b0;
                    end
                end
            end
        end
    end

    // A response for a slot with nothing outstanding is a protocol error upstream.
    response_slot_valid: assert property (@(posedge clk_i) disable iff (rst_i) pop |-> tbl[pop_idx].valid);

endmodule

// File: rtl/cluster_narrow_id_remap.sv
// rtl/cluster_narrow_id_remap.sv - compresses cluster narrow_out AXI IDs into a dense SoC-side ID space
module cluster_narrow_id_remap
    import cluster_narrow_id_remap_pkg::*;
#(
    parameter int unsigned SlvIdWidth   = NarrowIdWidthOut,
    parameter int unsigned MstIdWidth   = AXI_IW,
    parameter int unsigned MaxUniqIds   = 4,
    parameter int unsigned MaxTxnsPerId = 4,
    parameter type slv_req_t  = narrow_out_req_t,
    parameter type slv_resp_t = narrow_out_resp_t,
    parameter type mst_req_t  = narrow_in_req_t,
    parameter type mst_resp_t = narrow_in_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  slv_req_t  slv_req_i,
    output slv_resp_t slv_resp_o,
    output mst_req_t  mst_req_o,
    input  mst_resp_t mst_resp_i,
    output logic      busy_o
);

    localparam int unsigned IdxWidth = idx_width(MaxUniqIds);

    logic                  rd_stall, wr_stall;
    logic [IdxWidth-1:0]   rd_slot, wr_slot;
    logic [SlvIdWidth-1:0] rd_orig_id, wr_orig_id;
    logic                  rd_busy, wr_busy;
    logic                  rd_push, wr_push, rd_pop, wr_pop;

    // Table bookkeeping strobes: request handshakes and final-beat response handshakes.
    always_comb begin
        rd_push = slv_req_i.ar_valid && mst_resp_i.ar_ready && !rd_stall;
        wr_push = slv_req_i.aw_valid && mst_resp_i.aw_ready && !wr_stall;
        rd_pop  = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
        wr_pop  = mst_resp_i.b_valid && slv_req_i.b_ready;
        busy_o  = rd_busy || wr_busy;
    end

    cluster_id_remap_table #(
        .IdWidth      (SlvIdWidth),
        .MaxUniqIds   (MaxUniqIds),
        .MaxTxnsPerId (MaxTxnsPerId),
        .IdxWidth     (IdxWidth)
    ) i_rd_table (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_id      (slv_req_i.ar.id),
        .push        (rd_push),
        .stall       (rd_stall),
        .slot        (rd_slot),
        .pop         (rd_pop),
        .pop_idx     (mst_resp_i.r.id[IdxWidth-1:0]),
        .pop_orig_id (rd_orig_id),
        .busy        (rd_busy)
    );

    cluster_id_remap_table #(
        .IdWidth      (SlvIdWidth),
        .MaxUniqIds   (MaxUniqIds),
        .MaxTxnsPerId (MaxTxnsPerId),
        .IdxWidth     (IdxWidth)
    ) i_wr_table (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_id      (slv_req_i.aw.id),
        .push        (wr_push),
        .stall       (wr_stall),
        .slot        (wr_slot),
        .pop         (wr_pop),
        .pop_idx     (mst_resp_i.b.id[IdxWidth-1:0]),
        .pop_orig_id (wr_orig_id),
        .busy        (wr_busy)
    );

    // Downstream request: IDs replaced by slot index, valids gated by stall, all else forwarded.
    always_comb begin
        mst_req_o             = '0;
        mst_req_o.aw.id       = MstIdWidth'(wr_slot);
        mst_req_o.aw.addr     = slv_req_i.aw.addr;
        mst_req_o.aw.len      = slv_req_i.aw.len;
        mst_req_o.aw.size     = slv_req_i.aw.size;
        mst_req_o.aw.burst    = slv_req_i.aw.burst;
        mst_req_o.aw.lock     = slv_req_i.aw.lock;
        mst_req_o.aw.cache    = slv_req_i.aw.cache;
        mst_req_o.aw.prot     = slv_req_i.aw.prot;
        mst_req_o.aw.qos      = slv_req_i.aw.qos;
        mst_req_o.aw.region   = slv_req_i.aw.region;
        mst_req_o.aw.atop     = slv_req_i.aw.atop;
        mst_req_o.aw.user     = slv_req_i.aw.user;
        mst_req_o.aw_valid    = slv_req_i.aw_valid && !wr_stall;
        mst_req_o.w           = slv_req_i.w;
        mst_req_o.w_valid     = slv_req_i.w_valid;
        mst_req_o.b_ready     = slv_req_i.b_ready;
        mst_req_o.ar.id       = MstIdWidth'(rd_slot);
        mst_req_o.ar.addr     = slv_req_i.ar.addr;
        mst_req_o.ar.len      = slv_req_i.ar.len;
        mst_req_o.ar.size     = slv_req_i.ar.size;
        mst_req_o.ar.burst    = slv_req_i.ar.burst;
        mst_req_o.ar.lock     = slv_req_i.ar.lock;
        mst_req_o.ar.cache    = slv_req_i.ar.cache;
        mst_req_o.ar.prot     = slv_req_i.ar.prot;
        mst_req_o.ar.qos      = slv_req_i.ar.qos;
        mst_req_o.ar.region   = slv_req_i.ar.region;
        mst_req_o.ar.user     = slv_req_i.ar.user;
        mst_req_o.ar_valid    = slv_req_i.ar_valid && !rd_stall;
        mst_req_o.r_ready     = slv_req_i.r_ready;
    end

    // Upstream response: original IDs restored from the table, readies gated by stall.
    always_comb begin
        slv_resp_o          = '0;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && !wr_stall;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && !rd_stall;
        slv_resp_o.w_ready  = mst_resp_i.w_ready;
        slv_resp_o.b_valid  = mst_resp_i.b_valid;
        slv_resp_o.b.id     = wr_orig_id;
        slv_resp_o.b.resp   = mst_resp_i.b.resp;
        slv_resp_o.b.user   = mst_resp_i.b.user;
        slv_resp_o.r_valid  = mst_resp_i.r_valid;
        slv_resp_o.r.id     = rd_orig_id;
        slv_resp_o.r.data   = mst_resp_i.r.data;
        slv_resp_o.r.resp   = mst_resp_i.r.resp;
        slv_resp_o.r.last   = mst_resp_i.r.last;
        slv_resp_o.r.user   = mst_resp_i.r.user;
    end

endmodule

// File: tb/tb_cluster_narrow_id_remap.sv
// tb/tb_cluster_narrow_id_remap.sv - self-checking bench for cluster_narrow_id_remap
module tb_cluster_narrow_id_remap;
    import cluster_narrow_id_remap_pkg::*;

    localparam int MAXU = 4;
    localparam int MAXT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    narrow_out_req_t  slv_req;
    narrow_out_resp_t slv_resp;
    narrow_in_req_t   mst_req;
    narrow_in_resp_t  mst_resp;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    cluster_narrow_id_remap dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .slv_req_i  (slv_req),
        .slv_resp_o (slv_resp),
        .mst_req_o  (mst_req),
        .mst_resp_i (mst_resp),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    // Model: list of outstanding transactions, each remembering its original ID and slot.
    typedef struct {
        int unsigned id;
        int unsigned slot;
    } txn_t;
    typedef txn_t txn_q_t[$];

    txn_q_t rd_q;
    txn_q_t wr_q;

    function automatic txn_t mk(input int unsigned id, input int unsigned slot);
        txn_t t;
        t.id   = id;
        t.slot = slot;
        return t;
    endfunction

    function automatic int m_slot_of(input txn_q_t q, input int unsigned id);
        foreach (q[i]) if (q[i].id == id) return int'(q[i].slot);
        return -1;
    endfunction

    function automatic int m_count(input txn_q_t q, input int unsigned id);
        int n = 0;
        foreach (q[i]) if (q[i].id == id) n++;
        return n;
    endfunction

    function automatic int m_lowest_free(input txn_q_t q);
        for (int s = 0; s < MAXU; s++) begin
            bit used = 1'b0;
            foreach (q[i]) if (q[i].slot == s) used = 1'b1;
            if (!used) return s;
        end
        return -1;
    endfunction

    function automatic bit m_stall(input txn_q_t q, input int unsigned id);
        if (m_slot_of(q, id) >= 0) return m_count(q, id) >= MAXT;
        return m_lowest_free(q) < 0;
    endfunction

    function automatic int m_pick(input txn_q_t q, input int unsigned id);
        int s = m_slot_of(q, id);
        return (s >= 0) ? s : m_lowest_free(q);
    endfunction

    function automatic int m_orig(input txn_q_t q, input int unsigned slot);
        foreach (q[i]) if (q[i].slot == slot) return int'(q[i].id);
        return -1;
    endfunction

    function automatic int m_first_in_slot(input txn_q_t q, input int unsigned slot);
        foreach (q[i]) if (q[i].slot == slot) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model update on each handshake, using the pre-update transaction list for decisions.
    bit m_ar_hs, m_aw_hs;
    int m_ar_slot, m_aw_slot, m_idx;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q.delete();
            wr_q.delete();
        end else begin
            m_ar_hs   = slv_req.ar_valid && mst_resp.ar_ready && !m_stall(rd_q, 32'(slv_req.ar.id));
            m_ar_slot = m_pick(rd_q, 32'(slv_req.ar.id));
            m_aw_hs   = slv_req.aw_valid && mst_resp.aw_ready && !m_stall(wr_q, 32'(slv_req.aw.id));
            m_aw_slot = m_pick(wr_q, 32'(slv_req.aw.id));
            if (mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last) begin
                m_idx = m_first_in_slot(rd_q, 32'(mst_resp.r.id) % MAXU);
                if (m_idx >= 0) rd_q.delete(m_idx);
            end
            if (mst_resp.b_valid && slv_req.b_ready) begin
                m_idx = m_first_in_slot(wr_q, 32'(mst_resp.b.id) % MAXU);
                if (m_idx >= 0) wr_q.delete(m_idx);
            end
            if (m_ar_hs) rd_q.push_back(mk(32'(slv_req.ar.id), 32'(m_ar_slot)));
            if (m_aw_hs) wr_q.push_back(mk(32'(slv_req.aw.id), 32'(m_aw_slot)));
        end
    end

    // Every-cycle comparison of DUT outputs against the model, away from the active edge.
    bit c_ar_st, c_aw_st;
    always @(negedge clk) begin
        if (!rst) begin
            c_ar_st = m_stall(rd_q, 32'(slv_req.ar.id));
            c_aw_st = m_stall(wr_q, 32'(slv_req.aw.id));
            chk("busy", 64'(busy), 64'((rd_q.size() + wr_q.size()) != 0));
            chk("ar_ready", 64'(slv_resp.ar_ready), 64'(mst_resp.ar_ready && !c_ar_st));
            chk("ar_valid", 64'(mst_req.ar_valid), 64'(slv_req.ar_valid && !c_ar_st));
            chk("aw_ready", 64'(slv_resp.aw_ready), 64'(mst_resp.aw_ready && !c_aw_st));
            chk("aw_valid", 64'(mst_req.aw_valid), 64'(slv_req.aw_valid && !c_aw_st));
            if (slv_req.ar_valid && !c_ar_st) begin
                chk("ar_id", 64'(mst_req.ar.id), 64'(m_pick(rd_q, 32'(slv_req.ar.id))));
                chk("ar_addr", 64'(mst_req.ar.addr), 64'(slv_req.ar.addr));
            end
            if (slv_req.aw_valid && !c_aw_st) begin
                chk("aw_id", 64'(mst_req.aw.id), 64'(m_pick(wr_q, 32'(slv_req.aw.id))));
                chk("aw_addr", 64'(mst_req.aw.addr), 64'(slv_req.aw.addr));
            end
            if (mst_resp.r_valid) begin
                chk("r_id", 64'(slv_resp.r.id), 64'(m_orig(rd_q, 32'(mst_resp.r.id) % MAXU)));
                chk("r_data", slv_resp.r.data, mst_resp.r.data);
            end
            if (mst_resp.b_valid) begin
                chk("b_id", 64'(slv_resp.b.id), 64'(m_orig(wr_q, 32'(mst_resp.b.id) % MAXU)));
            end
            chk("w_data", mst_req.w.data, slv_req.w.data);
            chk("w_valid", 64'(mst_req.w_valid), 64'(slv_req.w_valid));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic ar_issue(input int id, input int exp_slot, input string name);
        slv_req.ar_valid = 1'b1;
        slv_req.ar.id    = 6'(id);
        slv_req.ar.addr  = 32'h1000 + 32'(id);
        #1;
        chk({name, "_ar_ready"}, 64'(slv_resp.ar_ready), 64'd1);
        chk({name, "_ar_slot"}, 64'(mst_req.ar.id), 64'(exp_slot));
        tick;
        slv_req.ar_valid = 1'b0;
    endtask

    task automatic aw_issue(input int id, input int exp_slot, input string name);
        slv_req.aw_valid = 1'b1;
        slv_req.aw.id    = 6'(id);
        slv_req.aw.addr  = 32'h2000 + 32'(id);
        #1;
        chk({name, "_aw_ready"}, 64'(slv_resp.aw_ready), 64'd1);
        chk({name, "_aw_slot"}, 64'(mst_req.aw.id), 64'(exp_slot));
        tick;
        slv_req.aw_valid = 1'b0;
    endtask

    task automatic r_last(input int slot, input int exp_id, input string name);
        mst_resp.r_valid = 1'b1;
        mst_resp.r.id    = 4'(slot);
        mst_resp.r.last  = 1'b1;
        mst_resp.r.data  = 64'hcafe_0000 + 64'(slot);
        #1;
        chk({name, "_r_id"}, 64'(slv_resp.r.id), 64'(exp_id));
        tick;
        mst_resp.r_valid = 1'b0;
    endtask

    task automatic b_ret(input int slot, input int exp_id, input string name);
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id    = 4'(slot);
        #1;
        chk({name, "_b_id"}, 64'(slv_resp.b.id), 64'(exp_id));
        tick;
        mst_resp.b_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        slv_req           = '0;
        mst_resp          = '0;
        mst_resp.ar_ready = 1'b1;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        slv_req.r_ready   = 1'b1;
        slv_req.b_ready   = 1'b1;
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ar_ready", 64'(slv_resp.ar_ready), 64'd1);
        chk("reset_aw_ready", 64'(slv_resp.aw_ready), 64'd1);
        repeat (2) tick;
        rst = 1'b0;
        tick;

        // Single read with W passthrough alongside.
        slv_req.w_valid = 1'b1;
        slv_req.w.data  = 64'h0123_4567_89ab_cdef;
        ar_issue(5, 0, "t1");
        slv_req.w_valid = 1'b0;
        mst_resp.r_valid = 1'b1;
        mst_resp.r.id    = 4'd0;
        mst_resp.r.last  = 1'b1;
        mst_resp.r.data  = 64'hdead_beef;
        #1;
        chk("t1_r_id", 64'(slv_resp.r.id), 64'd5);
        chk("t1_busy_hold", 64'(busy), 64'd1);
        tick;
        mst_resp.r_valid = 1'b0;
        #1;
        chk("t1_busy_fall", 64'(busy), 64'd0);

        // Same-ID reuse, then a new ID takes the next slot.
        ar_issue(3, 0, "t2a");
        ar_issue(3, 0, "t2b");
        ar_issue(3, 0, "t2c");
        ar_issue(7, 1, "t2d");
        r_last(0, 3, "t2e");
        r_last(0, 3, "t2f");
        r_last(1, 7, "t2g");
        r_last(0, 3, "t2h");
        #1;
        chk("t2_busy_end", 64'(busy), 64'd0);

        // Saturation on a single write ID.
        for (int i = 0; i < 4; i++) aw_issue(2, 0, "t3");
        slv_req.aw_valid = 1'b1;
        slv_req.aw.id    = 6'd2;
        #1;
        chk("t3_sat_ready", 64'(slv_resp.aw_ready), 64'd0);
        chk("t3_sat_valid", 64'(mst_req.aw_valid), 64'd0);
        tick;
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id    = 4'd0;
        #1;
        chk("t3_release_cycle_ready", 64'(slv_resp.aw_ready), 64'd0);
        chk("t3_b_id", 64'(slv_resp.b.id), 64'd2);
        tick;
        mst_resp.b_valid = 1'b0;
        #1;
        chk("t3_after_ready", 64'(slv_resp.aw_ready), 64'd1);
        chk("t3_after_slot", 64'(mst_req.aw.id), 64'd0);
        tick;
        slv_req.aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) b_ret(0, 2, "t3_drain");
        #1;
        chk("t3_busy_end", 64'(busy), 64'd0);

        // Table full: a fifth ID waits for a slot, and not within the freeing cycle.
        ar_issue(1, 0, "t4a");
        ar_issue(2, 1, "t4b");
        ar_issue(3, 2, "t4c");
        ar_issue(4, 3, "t4d");
        slv_req.ar_valid = 1'b1;
        slv_req.ar.id    = 6'd9;
        #1;
        chk("t4_full_ready", 64'(slv_resp.ar_ready), 64'd0);
        mst_resp.r_valid = 1'b1;
        mst_resp.r.id    = 4'd2;
        mst_resp.r.last  = 1'b1;
        #1;
        chk("t4_free_cycle_ready", 64'(slv_resp.ar_ready), 64'd0);
        chk("t4_free_r_id", 64'(slv_resp.r.id), 64'd3);
        tick;
        mst_resp.r_valid = 1'b0;
        #1;
        chk("t4_alloc_ready", 64'(slv_resp.ar_ready), 64'd1);
        chk("t4_alloc_slot", 64'(mst_req.ar.id), 64'd2);
        tick;
        slv_req.ar_valid = 1'b0;
        r_last(0, 1, "t4e");
        r_last(1, 2, "t4f");
        r_last(3, 4, "t4g");
        r_last(2, 9, "t4h");

        // Reuse and release of the same slot in one cycle.
        ar_issue(6, 0, "t5a");
        slv_req.ar_valid = 1'b1;
        slv_req.ar.id    = 6'd6;
        mst_resp.r_valid = 1'b1;
        mst_resp.r.id    = 4'd0;
        mst_resp.r.last  = 1'b1;
        #1;
        chk("t5_ready", 64'(slv_resp.ar_ready), 64'd1);
        chk("t5_slot", 64'(mst_req.ar.id), 64'd0);
        chk("t5_r_id", 64'(slv_resp.r.id), 64'd6);
        tick;
        slv_req.ar_valid = 1'b0;
        mst_resp.r_valid = 1'b0;
        #1;
        chk("t5_still_busy", 64'(busy), 64'd1);
        r_last(0, 6, "t5b");
        #1;
        chk("t5_busy_end", 64'(busy), 64'd0);

        // Asynchronous reset in the middle of a read burst.
        ar_issue(8, 0, "t6a");
        ar_issue(5, 1, "t6b");
        mst_resp.r_valid = 1'b1;
        mst_resp.r.id    = 4'd1;
        mst_resp.r.last  = 1'b0;
        #1;
        chk("t6_burst_r_id", 64'(slv_resp.r.id), 64'd5);
        tick;
        tick;
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_busy", 64'(busy), 64'd0);
        mst_resp.r_valid = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        ar_issue(5, 0, "t6c");
        r_last(0, 5, "t6d");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
